// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator running on the board clock.
// A divider on clock_50 produces pix_en. Sync and blank are registered from the next-state counters so they line up with x/y.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11
) (
  input  logic          clock_50,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pix_en,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          blank_n,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Elaboration-time guard: the counters must hold H_TOTAL-1 and V_TOTAL-1.
  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_cw_too_narrow
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          pix_tick;

  // Gated by reset_n so pix_en stays low while reset is held, even with CLK_DIV=1.
  assign pix_tick = reset_n && enable && (div_q == DIV_LAST);

  always_comb begin
    div_d   = '0;
    h_d     = '0;
    v_d     = '0;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    blank_d = 1'b0;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (pix_tick) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end else begin
          h_d = h_q + CW'(1);
        end
      end
      hs_d    = ((h_d >= H_SS) && (h_d < H_SE)) ? HS_POL : ~HS_POL;
      vs_d    = ((v_d >= V_SS) && (v_d < V_SE)) ? VS_POL : ~VS_POL;
      blank_d = (h_d < H_ACT) && (v_d < V_ACT);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end

  assign pix_en      = pix_tick;
  assign line_start  = pix_tick && (h_q == '0);
  assign frame_start = pix_tick && (h_q == '0) && (v_q == '0);
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign blank_n     = blank_q;
  assign x           = h_q;
  assign y           = v_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default, medium, tiny) share clock, reset and enable.
// Expected outputs come from an arithmetic model driven by the count of consecutive enabled edges.
module tb_vga_timing_gen;

  logic clock_50 = 1'b0;
  logic reset_n  = 1'b1;
  logic enable   = 1'b0;

  logic pix0, hs0, vs0, bl0, ls0, fs0;
  logic pix1, hs1, vs1, bl1, ls1, fs1;
  logic pix2, hs2, vs2, bl2, ls2, fs2;
  logic [10:0] x0, y0, x1, y1, x2, y2;

  int t = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock_50 = ~clock_50;

  vga_timing_gen d0 (
    .clock_50(clock_50), .reset_n(reset_n), .enable(enable),
    .pix_en(pix0), .vga_hs(hs0), .vga_vs(vs0), .blank_n(bl0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(11)
  ) d1 (
    .clock_50(clock_50), .reset_n(reset_n), .enable(enable),
    .pix_en(pix1), .vga_hs(hs1), .vga_vs(vs1), .blank_n(bl1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) d2 (
    .clock_50(clock_50), .reset_n(reset_n), .enable(enable),
    .pix_en(pix2), .vga_hs(hs2), .vga_vs(vs2), .blank_n(bl2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
  );

  // Consecutive enabled edges since the last reset or disabled edge.
  always @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n)    t <= 0;
    else if (enable) t <= t + 1;
    else             t <= 0;
  end

  function automatic logic [27:0] exp_vec(input int k);
    int cd, ha, hf, hsw, hb, va, vf, vsw, vb, htot, vtot, p, h, v;
    logic hp, vp, on, pe, hsx, vsx, bk, lsx, fsx;
    case (k)
      0:       begin cd = 2; ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; hp = 1'b0; vp = 1'b0; end
      1:       begin cd = 3; ha = 20;  hf = 3;  hsw = 4;  hb = 5;  va = 10;  vf = 2;  vsw = 3; vb = 4;  hp = 1'b0; vp = 1'b1; end
      default: begin cd = 1; ha = 4;   hf = 1;  hsw = 2;  hb = 1;  va = 3;   vf = 1;  vsw = 1; vb = 1;  hp = 1'b1; vp = 1'b1; end
    endcase
    htot = ha + hf + hsw + hb;
    vtot = va + vf + vsw + vb;
    on   = (t > 0);
    p    = t / cd;
    h    = p % htot;
    v    = (p / htot) % vtot;
    pe   = reset_n && enable && ((t % cd) == cd - 1);
    hsx  = (on && h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    vsx  = (on && v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    bk   = on && (h < ha) && (v < va);
    lsx  = pe && (h == 0);
    fsx  = lsx && (v == 0);
    return {pe, hsx, vsx, bk, lsx, fsx, 11'(h), 11'(v)};
  endfunction

  function automatic logic [27:0] got_vec(input int k);
    case (k)
      0:       return {pix0, hs0, vs0, bl0, ls0, fs0, x0, y0};
      1:       return {pix1, hs1, vs1, bl1, ls1, fs1, x1, y1};
      default: return {pix2, hs2, vs2, bl2, ls2, fs2, x2, y2};
    endcase
  endfunction

  // Drive one clock cycle's inputs shortly after the rising edge, then settle.
  task automatic cycle(input logic en, input logic rst);
    @(posedge clock_50);
    #1;
    enable  = en;
    reset_n = rst;
    #1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL reset_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
        end
      end
      n_checks++;
      if ({pix0, pix2, hs0, vs0, hs2, vs2, bl0, bl2, fs2, x0, y0} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0}) begin
        n_fail++;
        $display("FAIL reset_values got pix0=%b pix2=%b hs0=%b vs0=%b hs2=%b vs2=%b bl0=%b bl2=%b fs2=%b x0=%0d y0=%0d",
                 pix0, pix2, hs0, vs0, hs2, vs2, bl0, bl2, fs2, x0, y0);
      end
    end
  endtask

  task automatic test_run;
    int last_ls0 = -1, hs_low0 = 0, bl_hi0 = 0;
    int last_fs1 = -1, ls_cnt1 = 0, last_fs2 = -1, ls_cnt2 = 0;
    int first_fs0 = -1, first_fs2 = -1;
    cycle(1'b1, 1'b0);
    for (int c = 1; c <= 4000; c++) begin
      cycle(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL run_model inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
      if (fs0 && first_fs0 < 0) first_fs0 = c;
      if (fs2 && first_fs2 < 0) first_fs2 = c;
      if (ls0) begin
        if (last_ls0 >= 0) begin
          n_checks += 3;
          if (c - last_ls0 != 1600) begin n_fail++; $display("FAIL line_period got=%0d exp=1600", c - last_ls0); end
          if (hs_low0 != 192)       begin n_fail++; $display("FAIL hs_low_clocks got=%0d exp=192", hs_low0); end
          if (bl_hi0 != 1280)       begin n_fail++; $display("FAIL blank_hi_clocks got=%0d exp=1280", bl_hi0); end
        end
        last_ls0 = c; hs_low0 = 0; bl_hi0 = 0;
      end
      if (!hs0) hs_low0++;
      if (bl0) bl_hi0++;
      if (fs1) begin
        if (last_fs1 >= 0) begin
          n_checks += 2;
          if (c - last_fs1 != 1824) begin n_fail++; $display("FAIL frame_period_med got=%0d exp=1824", c - last_fs1); end
          if (ls_cnt1 != 19)        begin n_fail++; $display("FAIL lines_per_frame_med got=%0d exp=19", ls_cnt1); end
        end
        last_fs1 = c; ls_cnt1 = 0;
      end
      if (ls1) ls_cnt1++;
      if (fs2) begin
        if (last_fs2 >= 0) begin
          n_checks += 2;
          if (c - last_fs2 != 48) begin n_fail++; $display("FAIL frame_period_tiny got=%0d exp=48", c - last_fs2); end
          if (ls_cnt2 != 6)       begin n_fail++; $display("FAIL lines_per_frame_tiny got=%0d exp=6", ls_cnt2); end
        end
        last_fs2 = c; ls_cnt2 = 0;
      end
      if (ls2) ls_cnt2++;
    end
    n_checks += 2;
    if (first_fs0 != 2) begin n_fail++; $display("FAIL first_frame_start_def got=%0d exp=2", first_fs0); end
    if (first_fs2 != 1) begin n_fail++; $display("FAIL first_frame_start_tiny got=%0d exp=1", first_fs2); end
  endtask

  task automatic test_enable_drop;
    int first_fs0 = -1;
    int pre = $urandom_range(0, 300);
    for (int c = 0; c < pre; c++) begin
      cycle(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL drop_pre inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL drop_model inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
    end
    n_checks += 3;
    if ({pix0, x0, y0, bl0, hs0, vs0} !== {1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL idle_def got pix=%b x=%0d y=%0d bl=%b hs=%b vs=%b", pix0, x0, y0, bl0, hs0, vs0);
    end
    if ({pix1, x1, y1, bl1, hs1, vs1} !== {1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL idle_med got pix=%b x=%0d y=%0d bl=%b hs=%b vs=%b", pix1, x1, y1, bl1, hs1, vs1);
    end
    if ({pix2, x2, y2, bl2, hs2, vs2} !== {1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL idle_tiny got pix=%b x=%0d y=%0d bl=%b hs=%b vs=%b", pix2, x2, y2, bl2, hs2, vs2);
    end
    for (int c = 1; c <= 2000; c++) begin
      cycle(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL reenable_model inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
      if (fs0 && first_fs0 < 0) first_fs0 = c;
    end
    n_checks++;
    if (first_fs0 != 2) begin n_fail++; $display("FAIL reenable_first_frame got=%0d exp=2", first_fs0); end
  endtask

  task automatic test_async_reset;
    int pre = $urandom_range(500, 900);
    for (int c = 0; c < pre; c++) begin
      cycle(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL arst_pre inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({pix0, x0, y0, bl0, hs0, vs0, ls0, fs0} !== {1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL arst_values got pix=%b x=%0d y=%0d bl=%b hs=%b vs=%b", pix0, x0, y0, bl0, hs0, vs0);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL arst_model inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
      end
    end
    #2 reset_n = 1'b1;
    #1;
    n_checks++;
    if ({fs0, fs2} !== 2'b01) begin
      n_fail++; $display("FAIL arst_release_clk1 got fs0=%b fs2=%b exp fs0=0 fs2=1", fs0, fs2);
    end
    for (int c = 2; c <= 300; c++) begin
      cycle(1'b1, 1'b1);
      if (c == 2) begin
        n_checks++;
        if (fs0 !== 1'b1) begin n_fail++; $display("FAIL arst_release_clk2 got fs0=%b exp=1", fs0); end
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL arst_post inst%0d t=%0d got=%h exp=%h", k, t, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      cycle(logic'($urandom_range(0, 99) < 98), logic'($urandom_range(0, 299) != 0));
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random inst%0d t=%0d en=%b rst=%b got=%h exp=%h", k, t, enable, reset_n, got_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
